// File: rtl/fb_pkg.sv
// fb_pkg: shared state/request types, default geometry and sizing helpers
package fb_pkg;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int BPP_DEF = 4;
  localparam int WORD_W_DEF = 16;
  localparam int MAX_BPP = 32;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FILL} state_t;
  typedef struct packed {
    logic [9:0]         x;
    logic [9:0]         y;
    logic [MAX_BPP-1:0] color;
  } pix_req_t;
  function automatic int pix_per_word(input int word_w, input int bpp);
    return word_w / bpp;
  endfunction
  function automatic int fb_depth(input int h_res, input int v_res, input int word_w, input int bpp);
    return h_res * v_res / pix_per_word(word_w, bpp);
  endfunction
endpackage

// File: rtl/fb_lane_merge.sv
// fb_lane_merge: replaces one BPP-wide lane of a packed word with a colour
module fb_lane_merge #(
  parameter int WORD_W = 16,
  parameter int BPP = 4,
  parameter int LANE_W = 2
) (
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [BPP-1:0]    color,
  output logic [WORD_W-1:0] merged
);
  always_comb begin
    merged = word;
    merged[lane*BPP +: BPP] = color;
  end
endmodule

// File: rtl/fb_pixel_write_engine.sv
// fb_pixel_write_engine: read-modify-write pixel engine with hardware fill into a packed-pixel buffer
// FB_WRITE_COALESCE_EN adds a one-word write cache that skips the read for repeat hits on the same word.
module fb_pixel_write_engine import fb_pkg::*; #(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int BPP = BPP_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int RD_LAT = 1,
  localparam int PIX_PER_WORD = pix_per_word(WORD_W, BPP),
  localparam int DEPTH = fb_depth(H_RES, V_RES, WORD_W, BPP),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [BPP-1:0]    pix_color,
  input  logic              fill_start,
  input  logic [BPP-1:0]    fill_color,
  output logic              busy,
  output logic [15:0]       oor_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wr_data
);
  localparam int LANE_W = PIX_PER_WORD > 1 ? $clog2(PIX_PER_WORD) : 1;
  localparam int CNT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t state_q, state_d;
  pix_req_t req;
  logic [BPP-1:0] req_color, color_q, color_d, merge_color;
  logic [LANE_W-1:0] lane, lane_q, lane_d, merge_lane;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] word, mem_addr_q, mem_addr_d;
  logic mem_rd_en_q, mem_rd_en_d, mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_wr_data_q, mem_wr_data_d, merge_base, merged;
  logic [WORD_W-1:0] fill_chain [PIX_PER_WORD+1];
  logic [15:0] oor_count_q, oor_count_d;
  logic [31:0] lin;
  logic in_range, accept, hit;
  assign req = '{x: pix_x, y: pix_y, color: MAX_BPP'(pix_color)};
  assign req_color = BPP'(req.color);
  assign in_range = 32'(req.x) < H_RES && 32'(req.y) < V_RES;
  assign lin = 32'(req.y) * H_RES + 32'(req.x);
  assign word = ADDR_W'(lin / PIX_PER_WORD);
  assign lane = LANE_W'(lin % PIX_PER_WORD);
  assign pix_ready = !Reset && state_q == IDLE && !fill_start;
  assign accept = pix_valid && pix_ready;
  assign busy = state_q != IDLE;
  assign oor_count = oor_count_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_we = mem_we_q;
  assign mem_wr_data = mem_wr_data_q;
`ifdef FB_WRITE_COALESCE_EN
  logic cache_vld_q, cache_vld_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [WORD_W-1:0] cache_data_q, cache_data_d;
  assign hit = cache_vld_q && cache_addr_q == word;
  assign merge_base = state_q == IDLE ? cache_data_q : mem_rd_data;
  always_comb begin
    cache_vld_d = state_q == WRITE || (cache_vld_q && !(state_q == IDLE && fill_start));
    cache_addr_d = state_q == WRITE ? mem_addr_q : cache_addr_q;
    cache_data_d = state_q == WRITE ? mem_wr_data_q : cache_data_q;
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      cache_vld_q <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
    end
`else
  assign hit = 1'b0;
  assign merge_base = mem_rd_data;
`endif
  assign merge_lane = state_q == IDLE ? lane : lane_q;
  assign merge_color = state_q == IDLE ? req_color : color_q;
  fb_lane_merge #(.WORD_W(WORD_W), .BPP(BPP), .LANE_W(LANE_W)) u_merge (
    .word(merge_base), .lane(merge_lane), .color(merge_color), .merged(merged)
  );
  // Fill word is built by chaining the lane merger once per lane.
  assign fill_chain[0] = '0;
  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_fill
    fb_lane_merge #(.WORD_W(WORD_W), .BPP(BPP), .LANE_W(LANE_W)) u_rep (
      .word(fill_chain[i]), .lane(LANE_W'(i)), .color(fill_color), .merged(fill_chain[i+1])
    );
  end
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_en_d = 1'b0;
    mem_we_d = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    oor_count_d = oor_count_q;
    case (state_q)
      IDLE:
        if (fill_start) begin
          state_d = FILL;
          mem_we_d = 1'b1;
          mem_addr_d = '0;
          mem_wr_data_d = fill_chain[PIX_PER_WORD];
        end else if (accept && !in_range) begin
          oor_count_d = oor_count_q + 16'(~&oor_count_q);
        end else if (accept) begin
          state_d = hit ? WRITE : READ;
          mem_rd_en_d = !hit;
          mem_we_d = hit;
          mem_addr_d = word;
          lane_d = lane;
          color_d = req_color;
          mem_wr_data_d = hit ? merged : mem_wr_data_q;
        end
      READ: begin
        state_d = WAIT;
        cnt_d = CNT_W'(RD_LAT - 1);
      end
      WAIT:
        if (cnt_q == '0) begin
          state_d = WRITE;
          mem_we_d = 1'b1;
          mem_wr_data_d = merged;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      WRITE: state_d = IDLE;
      FILL:
        if (mem_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          mem_we_d = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      state_q <= IDLE;
      color_q <= '0;
      lane_q <= '0;
      cnt_q <= '0;
      mem_addr_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_wr_data_q <= '0;
      oor_count_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_we_q <= mem_we_d;
      mem_wr_data_q <= mem_wr_data_d;
      oor_count_q <= oor_count_d;
    end
endmodule

// File: tb/tb_fb_pixel_write_engine.sv
// tb_fb_pixel_write_engine: scoreboard bench with a behavioural frame-buffer model
module tb_fb_pixel_write_engine;
  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int PPW = 4;
  localparam int DEPTH = 19200;
  localparam int RD_LAT = 1;

  typedef struct {
    int          addr;
    logic [15:0] data;
    longint      cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [3:0] pix_color = '0;
  logic fill_start = 1'b0;
  logic [3:0] fill_color = '0;
  logic busy;
  logic [15:0] oor_count;
  logic [14:0] mem_addr;
  logic mem_rd_en;
  logic [15:0] mem_rd_data;
  logic mem_we;
  logic [15:0] mem_wr_data;

  fb_pixel_write_engine #(.RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .fill_start(fill_start),
    .fill_color(fill_color), .busy(busy), .oor_count(oor_count), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_we(mem_we), .mem_wr_data(mem_wr_data)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  longint cyc = 0;
  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t me;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] oor_m = '0;
  logic cvld = 1'b0;
  int cw = 0;
  int seed;

  // Buffer model: one-cycle-per-stage read pipeline, write port, init and pokes
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_pipe [RD_LAT];
  logic init_req = 1'b0;
  logic poke_en = 1'b0;
  int poke_a = 0;
  logic [15:0] poke_d = '0;
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 40503) ^ seed);
  endfunction

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (init_req) for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    if (poke_en) mem[poke_a] <= poke_d;
    if (mem_we) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or write
  always @(negedge Clk) begin
    #1;
    if (mem_rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_read: addr %0d at cycle %0d, none expected", mem_addr, cyc);
      end else begin
        me = rd_q.pop_front();
        check("rd_addr", 64'(mem_addr), 64'(me.addr));
        check("rd_cycle", 64'(cyc), 64'(me.cyc));
      end
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected", mem_addr, mem_wr_data, cyc);
      end else begin
        me = wr_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(me.addr));
        check("wr_data", 64'(mem_wr_data), 64'(me.data));
        check("wr_cycle", 64'(cyc), 64'(me.cyc));
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #2;
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    ref_mem[a] = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || rd_q.size() != 0 || wr_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic send_pixel(input int x, input int y, input logic [3:0] c, output longint t);
    int n = 0;
    int lin, w, ln;
    logic [15:0] d;
    logic h;
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y); pix_color = c;
    #1;
    while (pix_ready !== 1'b1 && n < 60) begin
      tick(); #1;
      n++;
    end
    t = cyc;
    if (pix_ready !== 1'b1) begin
      check("ready_timeout", 64'(pix_ready), 64'(1));
      pix_valid = 1'b0;
      return;
    end
    if (x >= H_RES || y >= V_RES) begin
      oor_m = (oor_m == 16'hffff) ? oor_m : oor_m + 16'd1;
      tick();
      pix_valid = 1'b0;
      #1;
      check("oor_count", 64'(oor_count), 64'(oor_m));
      check("oor_ready", 64'(pix_ready), 64'(1));
      return;
    end
    lin = y * H_RES + x;
    w = lin / PPW;
    ln = lin % PPW;
    d = ref_mem[w];
    d[ln*4 +: 4] = c;
    ref_mem[w] = d;
`ifdef FB_WRITE_COALESCE_EN
    h = cvld && cw == w;
`else
    h = 1'b0;
`endif
    if (!h) rd_q.push_back('{addr: w, data: 16'h0, cyc: t + 1});
    wr_q.push_back('{addr: w, data: d, cyc: h ? t + 1 : t + 2 + RD_LAT});
    cvld = 1'b1;
    cw = w;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [3:0] c, input int abort_at);
    longint t;
    int last;
    logic [15:0] fw;
    fill_start = 1'b1; fill_color = c;
    pix_valid = 1'b1; pix_x = 10'd7; pix_y = 10'd2; pix_color = 4'h3;
    #1;
    check("fill_priority_ready", 64'(pix_ready), 64'(0));
    t = cyc;
    fw = {4{c}};
    last = abort_at < 0 ? DEPTH - 1 : abort_at;
    for (int a = 0; a <= last; a++) begin
      wr_q.push_back('{addr: a, data: fw, cyc: t + 1 + a});
      ref_mem[a] = fw;
    end
    cvld = 1'b0;
    tick();
    for (int k = 0; k <= last; k++) begin
      check("fill_busy", 64'(busy), 64'(1));
      check("fill_ready", 64'(pix_ready), 64'(0));
      fill_start = (k == 50);
      fill_color = (k == 50) ? ~c : c;
      if (k < last) tick();
    end
    fill_start = 1'b0;
    if (abort_at >= 0) begin
      Reset = 1'b1;
      pix_valid = 1'b0;
      rd_q.delete(); wr_q.delete();
      oor_m = '0;
      tick();
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ready_low", 64'(pix_ready), 64'(0));
      check("rst_oor", 64'(oor_count), 64'(0));
      Reset = 1'b0;
      #1;
      check("rst_ready_high", 64'(pix_ready), 64'(1));
    end else begin
      tick();
      #1;
      check("fill_done_busy", 64'(busy), 64'(0));
      check("fill_done_ready", 64'(pix_ready), 64'(1));
      send_pixel(7, 2, 4'h3, t);
    end
  endtask

  initial begin
    longint t;
    int r0, x, y;
    seed = int'($urandom);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    init_req = 1'b1;
    tick(); tick();
    init_req = 1'b0;
    tick();
    check("reset_ready", 64'(pix_ready), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rd_en", 64'(mem_rd_en), 64'(0));
    check("reset_we", 64'(mem_we), 64'(0));
    check("reset_addr", 64'(mem_addr), 64'(0));
    check("reset_wr_data", 64'(mem_wr_data), 64'(0));
    check("reset_oor", 64'(oor_count), 64'(0));
    Reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(pix_ready), 64'(1));
    tick();

    poke(1, 16'h1234);
    poke(80, 16'hffff);
    send_pixel(5, 0, 4'ha, t);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("px1_ready_timing", 64'(pix_ready), 64'(k == 4));
      if (k < 4) tick();
    end
    send_pixel(3, 1, 4'h0, t);
    wait_idle();

    poke(1, 16'h0000);
    r0 = rd_cnt;
    send_pixel(4, 0, 4'h1, t);
    send_pixel(5, 0, 4'h2, t);
    wait_idle();
`ifdef FB_WRITE_COALESCE_EN
    check("coalesce_reads", 64'(rd_cnt - r0), 64'(1));
`else
    check("coalesce_reads", 64'(rd_cnt - r0), 64'(2));
`endif

    send_pixel(320, 0, 4'h7, t);
    send_pixel(0, 240, 4'h7, t);
    check("oor_two", 64'(oor_count), 64'(2));
    force dut.oor_count_q = 16'hfffe;
    tick();
    release dut.oor_count_q;
    oor_m = 16'hfffe;
    send_pixel(1023, 5, 4'h1, t);
    send_pixel(5, 1023, 4'h1, t);
    check("oor_saturated", 64'(oor_count), 64'(16'hffff));
    wait_idle();

    do_fill(4'h5, -1);
    wait_idle();
    do_fill(4'h9, 100);
    tick();

    for (int n = 0; n < 80; n++) begin
      r0 = $urandom_range(0, 9);
      x = (r0 == 0) ? $urandom_range(320, 1023) : $urandom_range(0, 15);
      y = (r0 == 1) ? $urandom_range(240, 1023) : (r0 == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 2));
      send_pixel(x, y, 4'($urandom), t);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    wait_idle();
    check("rd_queue_empty", 64'(rd_q.size()), 64'(0));
    check("wr_queue_empty", 64'(wr_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
